// File: rtl/compliment_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : compliment_pkg
//  Purpose  : Shared types and constants for the serial two's-complementer.
//             Holds the PASS/INVERT state encoding, the reset state and a
//             helper that forms the output bit from state and input bit.
//  Revision : 1.0 - initial release
// ============================================================================
package compliment_pkg;

  // PASS copies bits until the first 1 has gone by; INVERT flips the rest.
  typedef enum logic {
    PASS   = 1'b0,
    INVERT = 1'b1
  } cmp_state_t;

  localparam cmp_state_t CMP_RESET_STATE = PASS;

  // Output bit for a given state and serial input bit.
  function automatic logic cmp_out(input cmp_state_t st, input logic xb);
    return (st == INVERT) ? ~xb : xb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/compliment_word_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : compliment_word_ctr
//  Purpose  : Bit-position counter for fixed-length words. Counts accepted
//             bits and flags the last bit of each word so the FSM can
//             return to PASS for the next operand.
//  Ports    : clk   - rising-edge clock
//             reset - asynchronous, active-low reset (clears count to 0)
//             last  - high while count == WORD_LEN-1
//  Params   : WORD_LEN - operand length in bits (must be >= 1)
//  Revision : 1.0 - initial release
// ============================================================================
module compliment_word_ctr
  import compliment_pkg::*;
#(
  parameter int WORD_LEN = 1
) (
  input  logic clk,
  input  logic reset,
  output logic last
);

  // At least one bit wide so WORD_LEN=1 still yields a legal register.
  localparam int CW = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WORD_LEN - 1);

  logic [CW-1:0] count;

  assign last = (count == LAST_COUNT);

  // Explicit wrap keeps non-power-of-two word lengths correct.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (last) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/compliment.sv
`default_nettype none
// ============================================================================
//  Module   : compliment
//  Purpose  : Serial two's-complementer. Operand arrives LSB first on x, the
//             negated operand leaves LSB first on y. Bits are copied up to
//             and including the first 1, every later bit is inverted.
//  Ports    : clk   - rising-edge clock, x sampled on each rising edge
//             reset - asynchronous, active-low reset; starts a new word
//             x     - serial operand bit, LSB first
//             y     - serial two's-complement result bit, LSB first
//  Params   : WORD_LEN - 0: unbounded word, only reset starts a new word
//                        N>0: FSM returns to PASS after every N bits
//  Macros   : COMPLIMENT_REG_OUT_EN - when defined, y is registered
//             (1 clock latency, resets to 0); otherwise y is a zero-latency
//             Mealy output.
//  Revision : 1.0 - initial release
// ============================================================================
module compliment
  import compliment_pkg::*;
#(
  parameter int WORD_LEN = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic x,
  output logic y
);

  cmp_state_t state;
  cmp_state_t state_next;
  logic       word_last;

  generate
    if (WORD_LEN > 0) begin : g_word_ctr
      compliment_word_ctr #(
        .WORD_LEN (WORD_LEN)
      ) u_word_ctr (
        .clk   (clk),
        .reset (reset),
        .last  (word_last)
      );
    end else begin : g_no_word_ctr
      assign word_last = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CMP_RESET_STATE;
    end else begin
      state <= state_next;
    end
  end

  // The word boundary wins over PASS->INVERT so a 1 in the final bit of a
  // word cannot leak an inversion into the next word.
  always_comb begin
    state_next = state;
    if (word_last) begin
      state_next = PASS;
    end else if ((state == PASS) && x) begin
      state_next = INVERT;
    end
  end

`ifdef COMPLIMENT_REG_OUT_EN
  // Registered output uses the pre-edge state, giving the same stream as
  // the Mealy build delayed by one clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y <= 1'b0;
    end else begin
      y <= cmp_out(state, x);
    end
  end
`else
  // State is forced to PASS during reset, so y follows x there.
  assign y = cmp_out(state, x);
`endif

endmodule
`default_nettype wire

// File: tb/tb_compliment.sv
`default_nettype none
// ============================================================================
//  Module   : tb_compliment
//  Purpose  : Self-checking bench for the serial two's-complementer. Runs an
//             unbounded-word instance and a WORD_LEN=4 instance side by side
//             against an arithmetic reference: the expected bit i of a word
//             is bit i of (0 - value-of-bits-received-so-far).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_compliment;

  logic clk;
  logic reset;
  logic x;
  logic y0;
  logic y4;

  int tests;
  int fails;

  // Reference state: bits accumulated since the start of the current word.
  logic [63:0] acc0;
  int          n0;
  logic [3:0]  acc4;
  int          pos4;
  logic        prev0;
  logic        prev4;

  compliment #(.WORD_LEN(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .x     (x),
    .y     (y0)
  );

  compliment #(.WORD_LEN(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .x     (x),
    .y     (y4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    acc0  = '0;
    n0    = 0;
    acc4  = '0;
    pos4  = 0;
    prev0 = 1'b0;
    prev4 = 1'b0;
  endtask

  // Called at a falling edge: applies xb, checks y before the rising edge,
  // then advances the reference past that edge and returns at the next
  // falling edge.
  task automatic step(input logic xb, input string tag);
    logic [63:0] a0;
    logic [63:0] neg0;
    logic [3:0]  a4;
    logic [3:0]  neg4;
    logic        e0;
    logic        e4;
    x = xb;
    a0   = acc0 | (64'(xb) << n0);
    neg0 = 64'd0 - a0;
    e0   = neg0[n0];
    a4   = acc4 | (4'(xb) << pos4);
    neg4 = 4'd0 - a4;
    e4   = neg4[pos4];
    #2;
`ifdef COMPLIMENT_REG_OUT_EN
    check({tag, "_w0"}, y0, prev0);
    check({tag, "_w4"}, y4, prev4);
`else
    check({tag, "_w0"}, y0, e0);
    check({tag, "_w4"}, y4, e4);
`endif
    prev0 = e0;
    prev4 = e4;
    acc0  = a0;
    n0++;
    if (pos4 == 3) begin
      pos4 = 0;
      acc4 = '0;
    end else begin
      pos4++;
      acc4 = a4;
    end
    @(negedge clk);
  endtask

  // Called at a falling edge: asserts reset between edges, checks the
  // output while reset is low, releases reset at the next falling edge.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    x = 1'b0;
    #1;
`ifdef COMPLIMENT_REG_OUT_EN
    check({tag, "_rst_x0_w0"}, y0, 1'b0);
    check({tag, "_rst_x0_w4"}, y4, 1'b0);
`else
    check({tag, "_rst_x0_w0"}, y0, 1'b0);
    check({tag, "_rst_x0_w4"}, y4, 1'b0);
`endif
    x = 1'b1;
    #1;
`ifdef COMPLIMENT_REG_OUT_EN
    check({tag, "_rst_x1_w0"}, y0, 1'b0);
    check({tag, "_rst_x1_w4"}, y4, 1'b0);
`else
    check({tag, "_rst_x1_w0"}, y0, 1'b1);
    check({tag, "_rst_x1_w4"}, y4, 1'b1);
`endif
    x = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  initial begin
    logic [16:0] s1;
    logic [11:0] s2;
    logic [7:0]  s4;
    tests = 0;
    fails = 0;
    reset = 1'b0;
    x     = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);

    // Reset state and first word, unbounded length.
    do_reset("init");
    s1 = 17'b0_0001_0000_1110_0000;   // bit i = i-th bit sent
    for (int i = 0; i < 17; i++) step(s1[i], "s1");

    // First bit already 1: inversion starts at bit 1.
    do_reset("s2");
    s2 = 12'b1010_0010_1111;
    for (int i = 0; i < 12; i++) step(s2[i], "s2");

    // Reach INVERT, then reset between edges must force PASS at once.
    do_reset("s3");
    step(1'b1, "s3_go");
    step(1'b0, "s3_inv");
    do_reset("s3_async");

    // All-zero operand stays zero.
    for (int i = 0; i < 16; i++) step(1'b0, "zero");

    // Word boundary: second word restarts in PASS.
    do_reset("s4");
    s4 = 8'b0001_0010;
    for (int i = 0; i < 8; i++) step(s4[i], "w4");
    // A 1 on the final bit of a word must not carry over.
    for (int i = 0; i < 4; i++) step(1'b1, "w4_last1");
    for (int i = 0; i < 4; i++) step(1'b0, "w4_next");

    // Randomised words of random length, reset between bursts.
    for (int b = 0; b < 20; b++) begin
      int len;
      do_reset("rnd");
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) step(1'($urandom_range(0, 1)), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
